// File: rtl/rpm_dash_top.sv
// Gear/speed dashboard: debounced accel/decel buttons, per-gear speed ceiling,
// servo gauge, 4-digit FND scan and RGB/bar LED readout.
module rpm_dash_top #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TICK_HZ     = 1_000,
   parameter int DEBOUNCE_MS = 10,
   parameter int PWM_PERIOD  = 2_000_000,
   parameter int PWM_MIN     = 100_000,
   parameter int PWM_STEP    = 6_666
) (
   input  logic       clk_100mhz,
   input  logic       rst_btn,
   input  logic       btn_accel,
   input  logic       btn_decel,
   input  logic [2:0] gear_sw,
   output logic       servo_pwm,
   output logic [3:0] fnd_sel,
   output logic [7:0] fnd_seg,
   output logic [7:0] leds
);
   logic       tick_1khz;
   logic       accel_pulse;
   logic       decel_pulse;
   logic [3:0] speed_level;
   logic [3:0] max_level;
   logic [6:0] s5, m1, m2, m3, m4;

   rpm_clk_div #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_clk_div (
      .clk(clk_100mhz), .rst(rst_btn), .tick(tick_1khz));

   rpm_debounce #(.DB_N(DEBOUNCE_MS)) u_db_accel (
      .clk(clk_100mhz), .rst(rst_btn), .tick(tick_1khz), .btn(btn_accel), .pulse(accel_pulse));

   rpm_debounce #(.DB_N(DEBOUNCE_MS)) u_db_decel (
      .clk(clk_100mhz), .rst(rst_btn), .tick(tick_1khz), .btn(btn_decel), .pulse(decel_pulse));

   rpm_ctrl u_rpm_ctrl (
      .clk(clk_100mhz), .rst(rst_btn), .accel(accel_pulse), .decel(decel_pulse),
      .gear(gear_sw), .speed_level(speed_level), .max_level(max_level));

   rpm_fnd u_fnd (
      .clk(clk_100mhz), .rst(rst_btn), .tick(tick_1khz), .gear(gear_sw),
      .speed(speed_level), .fnd_sel(fnd_sel), .fnd_seg(fnd_seg));

   rpm_servo #(.PWM_PERIOD(PWM_PERIOD), .PWM_MIN(PWM_MIN), .PWM_STEP(PWM_STEP)) u_servo (
      .clk(clk_100mhz), .rst(rst_btn), .speed(speed_level), .pwm(servo_pwm));

   // Warning colour and 5-step bar; thresholds are multiples of the gear ceiling
   always_comb begin
      s5 = {3'b000, speed_level} * 7'd5;
      m1 = {3'b000, max_level};
      m2 = {m1[5:0], 1'b0};
      m3 = m1 + m2;
      m4 = {m1[4:0], 2'b00};
      if (speed_level >= max_level) begin
         leds[7:5] = 3'b100;
      end else if (speed_level >= {1'b0, max_level[3:1]}) begin
         leds[7:5] = 3'b110;
      end else begin
         leds[7:5] = 3'b010;
      end
      leds[0] = (speed_level != 4'd0);
      leds[1] = (s5 >= m1);
      leds[2] = (s5 >= m2);
      leds[3] = (s5 >= m3);
      leds[4] = (s5 >= m4);
   end
endmodule

module rpm_clk_div #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int HALF = CLK_HZ / (2 * TICK_HZ);
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_1khz_q, clk_1khz_d;
   logic          tick_q, tick_d;

   // Half-period counter; tick marks each rising edge of clk_1khz
   always_comb begin
      tick_d = (cnt_q == LAST) && !clk_1khz_q;
      if (cnt_q == LAST) begin
         cnt_d      = '0;
         clk_1khz_d = ~clk_1khz_q;
      end else begin
         cnt_d      = cnt_q + CW'(1);
         clk_1khz_d = clk_1khz_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         clk_1khz_q <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         clk_1khz_q <= clk_1khz_d;
         tick_q     <= tick_d;
      end
   end

   assign tick = tick_q;
endmodule

module rpm_debounce #(
   parameter int DB_N = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic pulse
);
   localparam int CW = (DB_N > 1) ? $clog2(DB_N) : 1;
   localparam logic [CW-1:0] LAST = CW'(DB_N - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lock_q, lock_d;
   logic          pulse_q, pulse_d;

   // lock stays set after a press (and out of reset) until a low sample is seen
   always_comb begin
      sync_d  = {sync_q[0], btn};
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      pulse_d = 1'b0;
      if (!tick) begin
         cnt_d = cnt_q;
      end else if (!sync_q[1]) begin
         cnt_d  = '0;
         lock_d = 1'b0;
      end else if (lock_q) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d   = '0;
         lock_d  = 1'b1;
         pulse_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b00;
         cnt_q   <= '0;
         lock_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;
endmodule

module rpm_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       accel,
   input  logic       decel,
   input  logic [2:0] gear,
   output logic [3:0] speed_level,
   output logic [3:0] max_level
);
   logic [3:0] speed_q, speed_d;

   // Per-gear ceiling
   always_comb begin
      case (gear)
         3'd0:    max_level = 4'd15;
         3'd1:    max_level = 4'd3;
         3'd2:    max_level = 4'd5;
         3'd3:    max_level = 4'd7;
         3'd4:    max_level = 4'd10;
         3'd5:    max_level = 4'd12;
         default: max_level = 4'd15;
      endcase
   end

   // Downshift clamp has priority over button pulses
   always_comb begin
      speed_d = speed_q;
      if (speed_q > max_level) begin
         speed_d = max_level;
      end else if (accel && !decel && (speed_q < max_level)) begin
         speed_d = speed_q + 4'd1;
      end else if (decel && !accel && (speed_q != 4'd0)) begin
         speed_d = speed_q - 4'd1;
      end else begin
         speed_d = speed_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         speed_q <= 4'd0;
      end else begin
         speed_q <= speed_d;
      end
   end

   assign speed_level = speed_q;
endmodule

module rpm_fnd (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [2:0] gear,
   input  logic [3:0] speed,
   output logic [3:0] fnd_sel,
   output logic [7:0] fnd_seg
);
   logic [1:0] idx_q, idx_d;
   logic [3:0] sel_q, sel_d;
   logic [7:0] seg_q, seg_d;
   logic [3:0] ones, tens;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // One digit per tick; code 15 renders blank
   always_comb begin
      idx_d = tick ? (idx_q + 2'd1) : idx_q;
      if (speed >= 4'd10) begin
         tens = 4'd1;
         ones = speed - 4'd10;
      end else begin
         tens = 4'd0;
         ones = speed;
      end
      case (idx_d)
         2'd0:    begin sel_d = 4'b1110; seg_d = seg7(ones); end
         2'd1:    begin sel_d = 4'b1101; seg_d = seg7(tens); end
         2'd2:    begin sel_d = 4'b1011; seg_d = seg7(4'd15); end
         2'd3:    begin sel_d = 4'b0111; seg_d = seg7({1'b0, gear}); end
         default: begin sel_d = 4'b1111; seg_d = 8'hFF; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= 2'd0;
         sel_q <= 4'b1110;
         seg_q <= 8'hC0;
      end else begin
         idx_q <= idx_d;
         sel_q <= sel_d;
         seg_q <= seg_d;
      end
   end

   assign fnd_sel = sel_q;
   assign fnd_seg = seg_q;
endmodule

module rpm_servo #(
   parameter int PWM_PERIOD = 2_000_000,
   parameter int PWM_MIN    = 100_000,
   parameter int PWM_STEP   = 6_666
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] speed,
   output logic       pwm
);
   localparam int CW = $clog2(PWM_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] width_q, width_d;
   logic          pwm_q, pwm_d;

   // Width only changes at frame wrap so a frame never gets a torn pulse
   always_comb begin
      if (cnt_q == LAST) begin
         cnt_d   = '0;
         width_d = CW'(PWM_MIN) + (CW'(speed) * CW'(PWM_STEP));
      end else begin
         cnt_d   = cnt_q + CW'(1);
         width_d = width_q;
      end
      pwm_d = (cnt_d < width_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         width_q <= CW'(PWM_MIN);
         pwm_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         width_q <= width_d;
         pwm_q   <= pwm_d;
      end
   end

   assign pwm = pwm_q;
endmodule

// File: tb/tb_rpm_dash_top.sv
// Bench for rpm_dash_top with a scaled-down clock (20 cycles per 1 ms tick) and short servo frame.
module tb_rpm_dash_top;
   localparam int MS     = 20;
   localparam int PERIOD = 2000;
   localparam int PMIN   = 100;
   localparam int PSTEP  = 6;

   logic       clk_100mhz = 1'b0;
   logic       rst_btn    = 1'b1;
   logic       btn_accel  = 1'b0;
   logic       btn_decel  = 1'b0;
   logic [2:0] gear_sw    = 3'd1;
   logic       servo_pwm;
   logic [3:0] fnd_sel;
   logic [7:0] fnd_seg;
   logic [7:0] leds;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] gear;
      logic       acc;
      logic       dec;
      logic [3:0] speed;
      logic [7:0] leds;
   } vec_t;

   typedef struct packed {
      logic [3:0] speed;
      logic [7:0] leds;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   rpm_dash_top #(
      .CLK_HZ(20_000), .TICK_HZ(1_000), .DEBOUNCE_MS(10),
      .PWM_PERIOD(PERIOD), .PWM_MIN(PMIN), .PWM_STEP(PSTEP)
   ) dut (
      .clk_100mhz(clk_100mhz), .rst_btn(rst_btn), .btn_accel(btn_accel),
      .btn_decel(btn_decel), .gear_sw(gear_sw), .servo_pwm(servo_pwm),
      .fnd_sel(fnd_sel), .fnd_seg(fnd_seg), .leds(leds)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic wait_ms(input int n);
      repeat (n * MS) @(negedge clk_100mhz);
   endtask

   task automatic press(input logic a, input logic d);
      btn_accel = a;
      btn_decel = d;
      wait_ms(20);
      btn_accel = 1'b0;
      btn_decel = 1'b0;
      wait_ms(5);
   endtask

   task automatic expect_state(input logic [3:0] sp, input logic [7:0] ld, input string name);
      exp_t e;
      sb.push_back('{sp, ld});
      @(negedge clk_100mhz);
      e = sb.pop_front();
      check({name, " leds"}, 32'(leds), 32'(e.leds));
      check({name, " speed"}, 32'(dut.u_rpm_ctrl.speed_level), 32'(e.speed));
   endtask

   task automatic apply(input vec_t v, input string name);
      gear_sw = v.gear;
      if (v.acc || v.dec) press(v.acc, v.dec);
      else wait_ms(2);
      expect_state(v.speed, v.leds, name);
   endtask

   task automatic wait_sel(input logic [3:0] want, output int cycles, output bit ok);
      cycles = 0;
      ok = 1'b0;
      while (cycles < 200) begin
         @(negedge clk_100mhz);
         cycles++;
         if (fnd_sel == want) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_pwm(input logic val, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
         @(negedge clk_100mhz);
         if (servo_pwm == val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int  cyc;
      bit  ok;
      int  hi_c, per_c;
      bit  low_seen, done;
      logic [3:0] sels [4];
      logic [7:0] segs [4];

      // gear, accel, decel, expected speed, expected leds
      tbl.push_back('{3'd1, 1'b0, 1'b1, 4'd0,  8'b010_00000});
      tbl.push_back('{3'd1, 1'b1, 1'b0, 4'd1,  8'b110_00011});
      tbl.push_back('{3'd1, 1'b1, 1'b0, 4'd2,  8'b110_01111});
      tbl.push_back('{3'd1, 1'b1, 1'b0, 4'd3,  8'b100_11111});
      tbl.push_back('{3'd1, 1'b1, 1'b0, 4'd3,  8'b100_11111});
      tbl.push_back('{3'd6, 1'b0, 1'b0, 4'd3,  8'b010_00011});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd4,  8'b010_00011});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd5,  8'b010_00011});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd6,  8'b010_00111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd7,  8'b110_00111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd8,  8'b110_00111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd9,  8'b110_01111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd10, 8'b110_01111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd11, 8'b110_01111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd12, 8'b110_11111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd13, 8'b110_11111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd14, 8'b110_11111});
      tbl.push_back('{3'd6, 1'b1, 1'b0, 4'd15, 8'b100_11111});
      tbl.push_back('{3'd6, 1'b0, 1'b1, 4'd14, 8'b110_11111});
      tbl.push_back('{3'd6, 1'b1, 1'b1, 4'd14, 8'b110_11111});
      tbl.push_back('{3'd2, 1'b0, 1'b0, 4'd5,  8'b100_11111});
      tbl.push_back('{3'd2, 1'b0, 1'b1, 4'd4,  8'b110_11111});
      tbl.push_back('{3'd0, 1'b0, 1'b1, 4'd3,  8'b010_00011});
      tbl.push_back('{3'd4, 1'b0, 1'b0, 4'd3,  8'b010_00011});

      // Reset state
      repeat (5) @(negedge clk_100mhz);
      check("rst fnd_sel", 32'(fnd_sel), 32'(4'b1110));
      check("rst servo", 32'(servo_pwm), 32'(1'b0));
      check("rst leds", 32'(leds), 32'(8'b010_00000));
      rst_btn = 1'b0;
      wait_ms(25);
      expect_state(4'd0, 8'b010_00000, "idle");
      check("idle max", 32'(dut.u_rpm_ctrl.max_level), 32'(4'd3));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Bounce then a clean hold: one increment only
      gear_sw = 3'd6;
      wait_ms(2);
      for (int k = 0; k < 14; k++) begin
         btn_accel = k[0];
         repeat (7) @(negedge clk_100mhz);
      end
      press(1'b1, 1'b0);
      expect_state(4'd4, 8'b010_00011, "bounce");

      for (int k = 0; k < 11; k++) press(1'b1, 1'b0);
      expect_state(4'd15, 8'b100_11111, "climb");

      // FND scan at gear 6 speed 15
      sels = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      segs = '{8'h92, 8'hF9, 8'hFF, 8'h82};
      wait_sel(4'b0111, cyc, ok);
      if (!ok) timeout("fnd sync0");
      wait_sel(4'b1110, cyc, ok);
      if (!ok) timeout("fnd sync1");
      else check("fnd seg0", 32'(fnd_seg), 32'(segs[0]));
      for (int d = 1; d < 4; d++) begin
         wait_sel(sels[d], cyc, ok);
         if (!ok) timeout($sformatf("fnd sel%0d", d));
         else begin
            check($sformatf("fnd interval%0d", d), 32'(cyc), 32'(MS));
            check($sformatf("fnd seg%0d", d), 32'(fnd_seg), 32'(segs[d]));
         end
      end

      // Servo high time and frame length at speed 15
      wait_pwm(1'b0, ok);
      if (ok) wait_pwm(1'b1, ok);
      if (!ok) timeout("servo edge");
      else begin
         hi_c = 0;
         per_c = 0;
         low_seen = 1'b0;
         done = 1'b0;
         for (int i = 0; i < 3 * PERIOD; i++) begin
            if (!low_seen && servo_pwm) hi_c++;
            else if (!servo_pwm) low_seen = 1'b1;
            else begin
               done = 1'b1;
               break;
            end
            per_c++;
            @(negedge clk_100mhz);
         end
         if (!done) timeout("servo frame");
         else begin
            check("servo high", 32'(hi_c), 32'(PMIN + 15 * PSTEP));
            check("servo period", 32'(per_c), 32'(PERIOD));
         end
      end

      // Reset in the middle of a held press: no increment until re-pressed
      gear_sw = 3'd1;
      wait_ms(2);
      btn_accel = 1'b1;
      wait_ms(8);
      rst_btn = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      rst_btn = 1'b0;
      wait_ms(15);
      btn_accel = 1'b0;
      wait_ms(5);
      expect_state(4'd0, 8'b010_00000, "rst midpress");
      press(1'b1, 1'b0);
      expect_state(4'd1, 8'b110_00011, "repress");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
